// File: rtl/segre_mm_arbiter.sv
// segre_mm_arbiter: sequences I-cache and D-cache line fills onto a single
// main-memory port. It keeps one memory transaction outstanding at a time.
// A dirty D-cache victim is written back before the matching D-cache fill.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   ic_req_i/ic_addr_i      I-cache miss (level, held until ic_rdy_o)
//   ic_rdy_o/ic_data_o      one-cycle fill pulse + filled line (held)
//   dc_req_i/dc_addr_i      D-cache miss (level, held until dc_rdy_o)
//   dc_wb_i/dc_wb_addr_i/dc_wb_data_i  dirty victim, sampled at grant
//   dc_rdy_o/dc_data_o      one-cycle fill pulse + filled line (held)
//   mm_rd_o/mm_addr_o       memory read request + line-aligned address
//   mm_wr_o/mm_wr_addr_o/mm_wr_data_o  memory write request
//   mm_data_rdy_i/mm_rd_data_i  memory completion pulse + read data
//   busy_o                  a transaction is in flight
module segre_mm_arbiter #(
  parameter int ADDR_SIZE = 32,
  parameter int LANE_SIZE = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ic_req_i,
  input  logic [ADDR_SIZE-1:0] ic_addr_i,
  output logic                 ic_rdy_o,
  output logic [LANE_SIZE-1:0] ic_data_o,
  input  logic                 dc_req_i,
  input  logic [ADDR_SIZE-1:0] dc_addr_i,
  input  logic                 dc_wb_i,
  input  logic [ADDR_SIZE-1:0] dc_wb_addr_i,
  input  logic [LANE_SIZE-1:0] dc_wb_data_i,
  output logic                 dc_rdy_o,
  output logic [LANE_SIZE-1:0] dc_data_o,
  output logic                 mm_rd_o,
  output logic                 mm_wr_o,
  output logic [ADDR_SIZE-1:0] mm_addr_o,
  output logic [ADDR_SIZE-1:0] mm_wr_addr_o,
  output logic [LANE_SIZE-1:0] mm_wr_data_o,
  input  logic                 mm_data_rdy_i,
  input  logic [LANE_SIZE-1:0] mm_rd_data_i,
  output logic                 busy_o
);

  localparam int OFF_BITS = $clog2(LANE_SIZE / 8);
  localparam logic [ADDR_SIZE-1:0] LINE_MASK = ~ADDR_SIZE'((1 << OFF_BITS) - 1);

  typedef enum logic [2:0] {IDLE, DC_WB, DC_RD, IC_RD, RESP_DC, RESP_IC} state_e;

  state_e                 state_q, state_d;
  logic                   last_dc_q, last_dc_d;   // 1: last grant went to DC
  logic [ADDR_SIZE-1:0]   dc_addr_q, dc_addr_d;   // fill address held across writeback
  logic                   ic_rdy_q, ic_rdy_d;
  logic                   dc_rdy_q, dc_rdy_d;
  logic [LANE_SIZE-1:0]   ic_data_q, ic_data_d;
  logic [LANE_SIZE-1:0]   dc_data_q, dc_data_d;
  logic                   mm_rd_q, mm_rd_d;
  logic                   mm_wr_q, mm_wr_d;
  logic [ADDR_SIZE-1:0]   mm_addr_q, mm_addr_d;
  logic [ADDR_SIZE-1:0]   mm_wr_addr_q, mm_wr_addr_d;
  logic [LANE_SIZE-1:0]   mm_wr_data_q, mm_wr_data_d;
  logic                   busy_q, busy_d;
  logic                   grant_ic, grant_dc;

  // Round-robin: on a tie, the requester that was not granted last wins.
  assign grant_ic = ic_req_i && (!dc_req_i || last_dc_q);
  assign grant_dc = dc_req_i && (!ic_req_i || !last_dc_q);

  always_comb begin
    state_d      = state_q;
    last_dc_d    = last_dc_q;
    dc_addr_d    = dc_addr_q;
    ic_rdy_d     = 1'b0;
    dc_rdy_d     = 1'b0;
    ic_data_d    = ic_data_q;
    dc_data_d    = dc_data_q;
    mm_rd_d      = mm_rd_q;
    mm_wr_d      = mm_wr_q;
    mm_addr_d    = mm_addr_q;
    mm_wr_addr_d = mm_wr_addr_q;
    mm_wr_data_d = mm_wr_data_q;
    unique case (state_q)
      IDLE: begin
        if (grant_ic) begin
          state_d   = IC_RD;
          last_dc_d = 1'b0;
          mm_rd_d   = 1'b1;
          mm_addr_d = ic_addr_i & LINE_MASK;
        end else if (grant_dc) begin
          last_dc_d = 1'b1;
          dc_addr_d = dc_addr_i & LINE_MASK;
          if (dc_wb_i) begin
            state_d      = DC_WB;
            mm_wr_d      = 1'b1;
            mm_wr_addr_d = dc_wb_addr_i & LINE_MASK;
            mm_wr_data_d = dc_wb_data_i;
          end else begin
            state_d   = DC_RD;
            mm_rd_d   = 1'b1;
            mm_addr_d = dc_addr_i & LINE_MASK;
          end
        end
      end
      DC_WB: begin
        // Write and read swap in the same edge, so they never overlap.
        if (mm_data_rdy_i) begin
          state_d   = DC_RD;
          mm_wr_d   = 1'b0;
          mm_rd_d   = 1'b1;
          mm_addr_d = dc_addr_q;
        end
      end
      DC_RD: begin
        if (mm_data_rdy_i) begin
          state_d   = RESP_DC;
          mm_rd_d   = 1'b0;
          dc_data_d = mm_rd_data_i;
          dc_rdy_d  = 1'b1;
        end
      end
      IC_RD: begin
        if (mm_data_rdy_i) begin
          state_d   = RESP_IC;
          mm_rd_d   = 1'b0;
          ic_data_d = mm_rd_data_i;
          ic_rdy_d  = 1'b1;
        end
      end
      RESP_DC, RESP_IC: state_d = IDLE;
      default:          state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_dc_q    <= 1'b0;
      dc_addr_q    <= '0;
      ic_rdy_q     <= 1'b0;
      dc_rdy_q     <= 1'b0;
      ic_data_q    <= '0;
      dc_data_q    <= '0;
      mm_rd_q      <= 1'b0;
      mm_wr_q      <= 1'b0;
      mm_addr_q    <= '0;
      mm_wr_addr_q <= '0;
      mm_wr_data_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_dc_q    <= last_dc_d;
      dc_addr_q    <= dc_addr_d;
      ic_rdy_q     <= ic_rdy_d;
      dc_rdy_q     <= dc_rdy_d;
      ic_data_q    <= ic_data_d;
      dc_data_q    <= dc_data_d;
      mm_rd_q      <= mm_rd_d;
      mm_wr_q      <= mm_wr_d;
      mm_addr_q    <= mm_addr_d;
      mm_wr_addr_q <= mm_wr_addr_d;
      mm_wr_data_q <= mm_wr_data_d;
      busy_q       <= busy_d;
    end
  end

  assign ic_rdy_o     = ic_rdy_q;
  assign dc_rdy_o     = dc_rdy_q;
  assign ic_data_o    = ic_data_q;
  assign dc_data_o    = dc_data_q;
  assign mm_rd_o      = mm_rd_q;
  assign mm_wr_o      = mm_wr_q;
  assign mm_addr_o    = mm_addr_q;
  assign mm_wr_addr_o = mm_wr_addr_q;
  assign mm_wr_data_o = mm_wr_data_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_segre_mm_arbiter.sv
// Scoreboard bench for segre_mm_arbiter: expected memory ops and cache
// responses are queued as stimulus is driven; a small memory model pops and
// checks ops, and the response monitor pops and checks rdy pulses.
module tb_segre_mm_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          ic_req_i = 1'b0, dc_req_i = 1'b0, dc_wb_i = 1'b0;
  logic [AW-1:0] ic_addr_i = '0, dc_addr_i = '0, dc_wb_addr_i = '0;
  logic [LW-1:0] dc_wb_data_i = '0, mm_rd_data_i = '0;
  logic          mm_data_rdy_i = 1'b0;
  logic          ic_rdy_o, dc_rdy_o, mm_rd_o, mm_wr_o, busy_o;
  logic [LW-1:0] ic_data_o, dc_data_o, mm_wr_data_o;
  logic [AW-1:0] mm_addr_o, mm_wr_addr_o;

  segre_mm_arbiter #(.ADDR_SIZE(AW), .LANE_SIZE(LW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_rdy_o(ic_rdy_o), .ic_data_o(ic_data_o),
    .dc_req_i(dc_req_i), .dc_addr_i(dc_addr_i), .dc_wb_i(dc_wb_i),
    .dc_wb_addr_i(dc_wb_addr_i), .dc_wb_data_i(dc_wb_data_i),
    .dc_rdy_o(dc_rdy_o), .dc_data_o(dc_data_o),
    .mm_rd_o(mm_rd_o), .mm_wr_o(mm_wr_o), .mm_addr_o(mm_addr_o),
    .mm_wr_addr_o(mm_wr_addr_o), .mm_wr_data_o(mm_wr_data_o),
    .mm_data_rdy_i(mm_data_rdy_i), .mm_rd_data_i(mm_rd_data_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; logic [AW-1:0] addr; logic [LW-1:0] data; } op_t;
  typedef struct { bit dc; logic [LW-1:0] data; } rsp_t;

  op_t           op_q[$];
  rsp_t          rsp_q[$];
  int            total = 0, bad = 0;
  int            cyc = 0, ic_cnt = 0, dc_cnt = 0, ic_cyc = 0, dc_cyc = 0;
  int            lat = 1, mem_cnt = 0;
  bit            mem_busy = 1'b0;
  logic [LW-1:0] mem_rdata = '0;

  task automatic chk(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic op_t mk_op(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
    op_t o;
    o.wr = wr; o.addr = a; o.data = d;
    return o;
  endfunction

  function automatic rsp_t mk_rsp(input bit dc, input logic [LW-1:0] d);
    rsp_t r;
    r.dc = dc; r.data = d;
    return r;
  endfunction

  // One cycle: monitor responses at the falling edge, then run the memory model.
  task automatic tick;
    rsp_t r;
    op_t  o;
    @(negedge clk);
    cyc++;
    if (mm_rd_o || mm_wr_o) chk("rd_wr_excl", LW'(mm_rd_o & mm_wr_o), '0);
    if (ic_rdy_o || dc_rdy_o) begin
      if (rsp_q.size() == 0) chk("unexpected_rdy", 1, 0);
      else begin
        r = rsp_q.pop_front();
        chk("rsp_cache", LW'(dc_rdy_o), LW'(r.dc));
        chk("rsp_one_hot", LW'(ic_rdy_o & dc_rdy_o), '0);
        chk("rsp_data", r.dc ? dc_data_o : ic_data_o, r.data);
      end
      if (ic_rdy_o) begin ic_cnt++; ic_cyc = cyc; ic_req_i = 1'b0; end
      if (dc_rdy_o) begin dc_cnt++; dc_cyc = cyc; dc_req_i = 1'b0; end
    end
    if (mm_data_rdy_i) mm_data_rdy_i = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mm_data_rdy_i = 1'b1;
        mm_rd_data_i  = mem_rdata;
        mem_busy      = 1'b0;
      end
    end else if (mm_rd_o || mm_wr_o) begin
      if (op_q.size() == 0) chk("unexpected_op", 1, 0);
      else begin
        o = op_q.pop_front();
        chk("op_kind_wr", LW'(mm_wr_o), LW'(o.wr));
        if (o.wr) begin
          chk("op_wr_addr", LW'(mm_wr_addr_o), LW'(o.addr));
          chk("op_wr_data", mm_wr_data_o, o.data);
        end else begin
          chk("op_rd_addr", LW'(mm_addr_o), LW'(o.addr));
          mem_rdata = o.data;
        end
      end
      mem_busy = 1'b1;
      mem_cnt  = lat;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_cnt(input int ic_t, input int dc_t, input string tag);
    int k = 0;
    while ((ic_cnt < ic_t || dc_cnt < dc_t) && k < 300) begin tick(); k++; end
    chk(tag, LW'(ic_cnt >= ic_t && dc_cnt >= dc_t), 1);
  endtask

  task automatic do_reset;
    rst_i = 1'b1; ic_req_i = 1'b0; dc_req_i = 1'b0; dc_wb_i = 1'b0;
    ticks(2);
    rst_i = 1'b0; mem_busy = 1'b0; mm_data_rdy_i = 1'b0;
    op_q.delete(); rsp_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},    LW'(busy_o), '0);
    chk({tag, "_ic_rdy"},  LW'(ic_rdy_o), '0);
    chk({tag, "_dc_rdy"},  LW'(dc_rdy_o), '0);
    chk({tag, "_mm_rd"},   LW'(mm_rd_o), '0);
    chk({tag, "_mm_wr"},   LW'(mm_wr_o), '0);
    chk({tag, "_mm_addr"}, LW'(mm_addr_o), '0);
    chk({tag, "_wr_addr"}, LW'(mm_wr_addr_o), '0);
    chk({tag, "_wr_data"}, mm_wr_data_o, '0);
    chk({tag, "_ic_data"}, ic_data_o, '0);
    chk({tag, "_dc_data"}, dc_data_o, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, ic0, dc0;
    logic [LW-1:0] a5, wbd, rdd;
    a5  = {16{8'hA5}};
    wbd = {4{32'hDEAD_BEEF}};
    rdd = {4{32'h1357_9BDF}};

    do_reset();
    chk_zero("reset");

    // Single IC miss, 2-cycle memory.
    lat = 2;
    op_q.push_back(mk_op(1'b0, 32'h0000_1230, a5));
    rsp_q.push_back(mk_rsp(1'b0, a5));
    ic_addr_i = 32'h0000_1234; ic_req_i = 1'b1;
    ticks(2);
    chk("t1_mm_rd", LW'(mm_rd_o), 1);
    chk("t1_mm_addr", LW'(mm_addr_o), LW'(32'h0000_1230));
    wait_cnt(1, 0, "t1_done");
    ticks(2);
    chk("t1_ic_once", LW'(ic_cnt), 1);
    chk("t1_dc_none", LW'(dc_cnt), 0);

    // DC miss with dirty victim: writeback then fill.
    lat = 1;
    op_q.push_back(mk_op(1'b1, 32'h0000_2000, wbd));
    op_q.push_back(mk_op(1'b0, 32'h0000_3000, rdd));
    rsp_q.push_back(mk_rsp(1'b1, rdd));
    dc_addr_i = 32'h0000_3008; dc_wb_addr_i = 32'h0000_2000; dc_wb_data_i = wbd;
    dc_wb_i = 1'b1; dc_req_i = 1'b1; c0 = cyc;
    wait_cnt(1, 1, "t2_done");
    chk("t2_latency", LW'(dc_cyc - c0), 5);
    dc_wb_i = 1'b0;
    ticks(2);
    chk("t2_dc_once", LW'(dc_cnt), 1);

    // DC miss, clean victim, minimum latency.
    op_q.push_back(mk_op(1'b0, 32'h0000_6010, a5 ^ rdd));
    rsp_q.push_back(mk_rsp(1'b1, a5 ^ rdd));
    dc_addr_i = 32'h0000_601F; dc_req_i = 1'b1; c0 = cyc;
    wait_cnt(1, 2, "t3_done");
    chk("t3_latency", LW'(dc_cyc - c0), 3);
    ticks(1);

    // Tie out of reset: DC, then IC, then (DC re-raised) IC wins a fresh tie.
    do_reset();
    ic_cnt = 0; dc_cnt = 0;
    op_q.push_back(mk_op(1'b0, 32'h0000_7000, {4{32'h1111_1111}}));
    op_q.push_back(mk_op(1'b0, 32'h0000_8010, {4{32'h2222_2222}}));
    rsp_q.push_back(mk_rsp(1'b1, {4{32'h1111_1111}}));
    rsp_q.push_back(mk_rsp(1'b0, {4{32'h2222_2222}}));
    dc_addr_i = 32'h0000_7004; ic_addr_i = 32'h0000_801C;
    dc_req_i = 1'b1; ic_req_i = 1'b1;
    wait_cnt(0, 1, "t4_dc_first");
    chk("t4_ic_waiting", LW'(ic_cnt), 0);
    ticks(1);
    op_q.push_back(mk_op(1'b0, 32'h0000_9020, {4{32'h3333_3333}}));
    rsp_q.push_back(mk_rsp(1'b1, {4{32'h3333_3333}}));
    dc_addr_i = 32'h0000_9020; dc_req_i = 1'b1;
    wait_cnt(1, 1, "t4_ic_second");
    chk("t4_dc_pending", LW'(dc_cnt), 1);
    wait_cnt(1, 2, "t4_dc_third");
    ticks(1);

    // Captured address survives input changes and a dropped request.
    lat = 3;
    op_q.push_back(mk_op(1'b0, 32'h0000_4440, {4{32'hCAFE_F00D}}));
    rsp_q.push_back(mk_rsp(1'b1, {4{32'hCAFE_F00D}}));
    dc_addr_i = 32'h0000_4447; dc_req_i = 1'b1;
    ticks(2);
    dc_addr_i = 32'h0000_9990; dc_req_i = 1'b0;
    tick();
    chk("t5_mm_rd", LW'(mm_rd_o), 1);
    chk("t5_addr_held", LW'(mm_addr_o), LW'(32'h0000_4440));
    wait_cnt(1, 3, "t5_done");
    ticks(2);
    chk("t5_dc_once", LW'(dc_cnt), 3);

    // Spurious completion in IDLE, then reset during IC_RD.
    ic0 = ic_cnt; dc0 = dc_cnt;
    mm_data_rdy_i = 1'b1;
    ticks(3);
    chk("t6_spur_busy", LW'(busy_o), 0);
    chk("t6_spur_rd", LW'(mm_rd_o | mm_wr_o), 0);
    lat = 4;
    op_q.push_back(mk_op(1'b0, 32'h0000_5550, a5));
    rsp_q.push_back(mk_rsp(1'b0, a5));
    ic_addr_i = 32'h0000_5550; ic_req_i = 1'b1;
    ticks(2);
    chk("t6_in_ic_rd", LW'(mm_rd_o), 1);
    do_reset();
    chk_zero("t6_rst");
    ticks(3);
    chk("t6_no_ic_rdy", LW'(ic_cnt), LW'(ic0));
    chk("t6_no_dc_rdy", LW'(dc_cnt), LW'(dc0));

    // After reset, the next tie goes to DC.
    lat = 1;
    op_q.push_back(mk_op(1'b0, 32'h0000_A000, {4{32'h4444_4444}}));
    op_q.push_back(mk_op(1'b0, 32'h0000_B000, {4{32'h5555_5555}}));
    rsp_q.push_back(mk_rsp(1'b1, {4{32'h4444_4444}}));
    rsp_q.push_back(mk_rsp(1'b0, {4{32'h5555_5555}}));
    dc_addr_i = 32'h0000_A00C; ic_addr_i = 32'h0000_B008;
    dc_req_i = 1'b1; ic_req_i = 1'b1;
    wait_cnt(ic0, dc0 + 1, "t6_tie_dc");
    chk("t6_tie_ic_after", LW'(ic_cnt), LW'(ic0));
    wait_cnt(ic0 + 1, dc0 + 1, "t6_tie_ic");
    ticks(2);
    chk("t6_queues_empty", LW'(op_q.size() + rsp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/segre_mm_arbiter.md
Name: segre_mm_arbiter

Overview:
- Sequences all core traffic to main memory.
- Arbitrates between instruction-cache line fills and data-cache line fills.
- Orders a dirty-victim writeback ahead of the matching data-cache fill.
- Sits between the I/D cache miss logic and the core's main-memory port, and owns the single outstanding main-memory transaction.

Parameters:
- ADDR_SIZE, 32, byte address width.
- LANE_SIZE, 128, cache line width in bits (power of two, ≥ 8).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- ic_req_i  in  1  I-cache miss request; level, held until ic_rdy_o
- ic_addr_i  in  ADDR_SIZE  I-cache miss address
- ic_rdy_o  out  1  one-cycle pulse; ic_data_o valid
- ic_data_o  out  LANE_SIZE  filled I-cache line
- dc_req_i  in  1  D-cache miss request; level, held until dc_rdy_o
- dc_addr_i  in  ADDR_SIZE  D-cache miss address
- dc_wb_i  in  1  victim is dirty; sampled with dc_req_i at grant
- dc_wb_addr_i  in  ADDR_SIZE  victim line address
- dc_wb_data_i  in  LANE_SIZE  victim line data
- dc_rdy_o  out  1  one-cycle pulse; dc_data_o valid
- dc_data_o  out  LANE_SIZE  filled D-cache line
- mm_rd_o  out  1  main-memory read request
- mm_wr_o  out  1  main-memory write request
- mm_addr_o  out  ADDR_SIZE  read address, line aligned
- mm_wr_addr_o  out  ADDR_SIZE  write address, line aligned
- mm_wr_data_o  out  LANE_SIZE  write data
- mm_data_rdy_i  in  1  memory completion pulse, for both read and write
- mm_rd_data_i  in  LANE_SIZE  read data; valid with mm_data_rdy_i
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant = IC. The next tie therefore goes to DC.
- All outputs are registered.
- FSM states: IDLE, DC_WB, DC_RD, IC_RD, RESP_DC, RESP_IC.
- IDLE transitions:
  - Only ic_req_i set: go to IC_RD.
  - Only dc_req_i set: go to DC_WB if dc_wb_i, else DC_RD.
  - Both set: round-robin; grant the requester not equal to last_grant.
  - On every grant, update last_grant.
- Capture at grant: addresses, plus wb addr/data when dc_wb_i. Later changes on the inputs are ignored for the rest of the transaction.
- Address alignment: low log2(LANE_SIZE/8) bits forced to 0 on mm_addr_o and mm_wr_addr_o.
- DC_WB: mm_wr_o=1 with captured wb addr/data, held until mm_data_rdy_i. On mm_data_rdy_i, drop mm_wr_o and go to DC_RD. No rdy pulse to the cache.
- DC_RD / IC_RD: mm_rd_o=1 with captured address, held until mm_data_rdy_i. On mm_data_rdy_i, drop mm_rd_o, register mm_rd_data_i into the matching data output, and go to RESP_x.
- mm_rd_o and mm_wr_o are never both 1.
- RESP_x: x_rdy_o=1 for exactly one cycle, then IDLE.
  - x_data_o holds its value until the next fill of the same cache.
  - The requester must drop req on the clock edge at the end of the rdy cycle. IDLE samples requests one cycle after RESP.
- Minimum latency, request to rdy: 3 cycles with a 1-cycle memory. Writeback adds 1 cycle plus the memory write latency.
- mm_data_rdy_i while in IDLE or RESP_x: ignored.
- A requester dropping req mid-transaction does not abort it. The transaction completes and the rdy pulse is still issued.
- A new request arriving while busy waits in the queue. No starvation: with both requesting continuously, grants alternate.
- Reset mid-transaction: the outstanding memory operation is abandoned, all outputs go to 0 next cycle, and data outputs are cleared.

Test Plan:
- Single IC miss, addr 0x0000_1234, memory returns 0xA5.. after 2 cycles -> mm_rd_o=1 with mm_addr_o=0x0000_1230; ic_rdy_o pulses once with ic_data_o=0xA5..; dc_rdy_o stays 0.
- DC miss with dc_wb_i=1 (wb addr 0x2000, miss addr 0x3008) -> mm_wr_o first at 0x2000 with the wb data; then mm_rd_o at 0x3000; one dc_rdy_o pulse; never simultaneous rd/wr.
- IC and DC requests asserted in the same cycle out of reset -> DC served first, then IC. Repeat the simultaneous request -> IC then DC (alternating).
- dc_addr_i changed and dc_req_i dropped while in DC_RD -> mm_addr_o keeps the captured address; dc_rdy_o still pulses once.
- Spurious mm_data_rdy_i in IDLE, then rst_i asserted during IC_RD -> no rdy pulses; after reset, all outputs 0, busy_o=0, and the next tie goes to DC.
